// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 VGA timing constants, mole-tile geometry and the
//   decoder FSM state type. The tile driver uses the same timing constants,
//   so both ends of the loopback agree on where every tile sits.
//   No ports (package).
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_LINE  = 800;

    // Vertical timing, in lines
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_FRAME = 525;
    localparam int VGA_V_TOL   = 1;

    // Tile geometry, relative to the start of the active area
    localparam int VGA_TILE_W    = 128;
    localparam int VGA_TILE_H    = 128;
    localparam int VGA_COL_PITCH = 129;
    localparam int VGA_ROW0_Y    = 128;
    localparam int VGA_ROW1_Y    = 257;
    localparam int VGA_MARGIN    = 8;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } dec_state_t;

    // True when more than one bit is set; zero and one-hot both return 0.
    function automatic logic is_multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/vga_frame_decoder_if.sv
// vga_frame_decoder_if
//   Bundles the sampled VGA stream and the decoder results.
//   master : drives pix_en, vga_in_hs/vs (active-low), vga_in_r/g/b (RGB565),
//            observes locked, slot_code, slot_valid, code_err, sync_err.
//   slave  : the decoder side (mirror directions).
interface vga_frame_decoder_if;
    logic       pix_en;
    logic       vga_in_hs;
    logic       vga_in_vs;
    logic [4:0] vga_in_r;
    logic [5:0] vga_in_g;
    logic [4:0] vga_in_b;

    logic       locked;
    logic [7:0] slot_code;
    logic       slot_valid;
    logic       code_err;
    logic       sync_err;

    modport master (
        output pix_en, vga_in_hs, vga_in_vs, vga_in_r, vga_in_g, vga_in_b,
        input  locked, slot_code, slot_valid, code_err, sync_err
    );

    modport slave (
        input  pix_en, vga_in_hs, vga_in_vs, vga_in_r, vga_in_g, vga_in_b,
        output locked, slot_code, slot_valid, code_err, sync_err
    );
endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter
//   Registers the VGA inputs on pix_en, detects sync edges against the
//   previous registered sample, rebuilds h_cnt/v_cnt and checks line and
//   frame lengths. A watchdog flags a stream with no hs falling edge.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     pix_en              pixel strobe; all state advances only here
//     hs_in, vs_in        active-low syncs
//     rgb_in              RGB565 pixel
//     h_cnt, v_cnt        current position (pre-update value this sample)
//     pix_lit             registered pixel is non-black
//     vs_fall             vs falling edge seen this sample (qualified by pix_en)
//     line_err            hs edge at the wrong h_cnt this sample
//     frame_err           vs falling edge with out-of-tolerance frame length
//     wd_fire             watchdog expiry this sample
module vga_sync_counter #(
    parameter int H_SYNC  = 96,
    parameter int H_LINE  = 800,
    parameter int V_FRAME = 525,
    parameter int V_TOL   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [15:0] rgb_in,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt,
    output logic        pix_lit,
    output logic        vs_fall,
    output logic        line_err,
    output logic        frame_err,
    output logic        wd_fire
);

    localparam int WD_LIMIT = 2 * H_LINE;

    logic        hs_q, hs_prev, vs_q, vs_prev;
    logic [15:0] rgb_q;
    logic [11:0] wd_cnt;
    logic        hs_fall, hs_rise;
    logic [10:0] frame_len;

    assign hs_fall = pix_en &  hs_prev & ~hs_q;
    assign hs_rise = pix_en & ~hs_prev &  hs_q;
    assign vs_fall = pix_en &  vs_prev & ~vs_q;
    assign pix_lit = (rgb_q != 16'd0);

    // Line length is checked on the fall, sync width on the rise.
    assign line_err = (hs_fall && (h_cnt != 11'(H_LINE - 1))) ||
                      (hs_rise && (h_cnt != 11'(H_SYNC - 1)));

    // v_cnt holds the last line index just before the vs fall, so +1 is the length.
    assign frame_len = {1'b0, v_cnt} + 11'd1;
    assign frame_err = vs_fall && ((frame_len < 11'(V_FRAME - V_TOL)) ||
                                   (frame_len > 11'(V_FRAME + V_TOL)));

    assign wd_fire = pix_en && !hs_fall && (wd_cnt == 12'(WD_LIMIT - 1));

    // Syncs reset to their idle (high) level so no edge appears out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_q    <= 1'b1;
            vs_prev <= 1'b1;
            rgb_q   <= 16'd0;
            h_cnt   <= 11'd0;
            v_cnt   <= 10'd0;
            wd_cnt  <= 12'd0;
        end else if (pix_en) begin
            hs_q    <= hs_in;
            hs_prev <= hs_q;
            vs_q    <= vs_in;
            vs_prev <= vs_q;
            rgb_q   <= rgb_in;

            if (hs_fall)
                h_cnt <= 11'd0;
            else if (h_cnt != 11'h7FF)
                h_cnt <= h_cnt + 11'd1;

            // vs clear has priority over the hs increment on the same sample.
            if (vs_fall)
                v_cnt <= 10'd0;
            else if (hs_fall && (v_cnt != 10'h3FF))
                v_cnt <= v_cnt + 10'd1;

            if (hs_fall || wd_fire)
                wd_cnt <= 12'd0;
            else
                wd_cnt <= wd_cnt + 12'd1;
        end
    end

endmodule

// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder
//   Receive side of the VGA tile loopback: locks to the sampled stream and
//   reports which of the 8 mole tiles were lit in the last complete frame.
//   Ports:
//     clk, rst_n   50 MHz clock, async active-low reset
//     bus (slave)  pix_en + VGA stream in; locked, slot_code, slot_valid,
//                  code_err, sync_err out
module vga_frame_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int H_LINE    = VGA_H_LINE,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int V_FRAME   = VGA_V_FRAME,
    parameter int V_TOL     = VGA_V_TOL,
    parameter int TILE_W    = VGA_TILE_W,
    parameter int TILE_H    = VGA_TILE_H,
    parameter int COL_PITCH = VGA_COL_PITCH,
    parameter int ROW0_Y    = VGA_ROW0_Y,
    parameter int ROW1_Y    = VGA_ROW1_Y,
    parameter int MARGIN    = VGA_MARGIN
) (
    input logic               clk,
    input logic               rst_n,
    vga_frame_decoder_if.slave bus
);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        pix_lit, vs_fall, line_err, frame_err, wd_fire;
    logic [31:0] h_pos, v_pos;
    logic [7:0]  tile_hit;

    dec_state_t  state;
    logic [7:0]  hits;
    logic        line_bad;
    logic        frame_bad_now;
    logic        locked_r, slot_valid_r, code_err_r, sync_err_r;
    logic [7:0]  slot_code_r;

    vga_sync_counter #(
        .H_SYNC  (H_SYNC),
        .H_LINE  (H_LINE),
        .V_FRAME (V_FRAME),
        .V_TOL   (V_TOL)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (bus.pix_en),
        .hs_in     (bus.vga_in_hs),
        .vs_in     (bus.vga_in_vs),
        .rgb_in    ({bus.vga_in_r, bus.vga_in_g, bus.vga_in_b}),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .pix_lit   (pix_lit),
        .vs_fall   (vs_fall),
        .line_err  (line_err),
        .frame_err (frame_err),
        .wd_fire   (wd_fire)
    );

    assign h_pos = 32'(h_cnt);
    assign v_pos = 32'(v_cnt);

    // Tile i sits in column i%4 and row i/4; the window is inset by MARGIN
    // so a pixel or two of sampling skew at the tile edge cannot matter.
    for (genvar i = 0; i < 8; i++) begin : g_tile
        localparam int X0  = H_SYNC + H_BP + (i % 4) * COL_PITCH;
        localparam int Y0  = V_SYNC + V_BP + ((i < 4) ? ROW0_Y : ROW1_Y);
        localparam int XLO = X0 + MARGIN;
        localparam int XHI = X0 + TILE_W - 1 - MARGIN;
        localparam int YLO = Y0 + MARGIN;
        localparam int YHI = Y0 + TILE_H - 1 - MARGIN;
        assign tile_hit[i] = pix_lit &&
                             (h_pos >= XLO) && (h_pos <= XHI) &&
                             (v_pos >= YLO) && (v_pos <= YHI);
    end

    // The hs fall that coincides with the vs fall also judges the last line.
    assign frame_bad_now = line_bad | line_err | frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEARCH;
            hits         <= 8'd0;
            line_bad     <= 1'b0;
            locked_r     <= 1'b0;
            slot_code_r  <= 8'd0;
            slot_valid_r <= 1'b0;
            code_err_r   <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            // Pulses drop on the clk after they were raised, pix_en or not.
            slot_valid_r <= 1'b0;
            sync_err_r   <= 1'b0;
            if (bus.pix_en) begin
                if (wd_fire) begin
                    state      <= SEARCH;
                    locked_r   <= 1'b0;
                    sync_err_r <= 1'b1;
                    hits       <= 8'd0;
                    line_bad   <= 1'b0;
                end else begin
                    case (state)
                        SEARCH: begin
                            if (vs_fall) begin
                                state    <= ALIGN;
                                hits     <= 8'd0;
                                line_bad <= 1'b0;
                            end
                        end
                        ALIGN: begin
                            if (vs_fall) begin
                                hits     <= 8'd0;
                                line_bad <= 1'b0;
                                if (frame_bad_now) begin
                                    sync_err_r <= 1'b1;
                                end else begin
                                    state    <= LOCKED;
                                    locked_r <= 1'b1;
                                end
                            end else begin
                                line_bad <= line_bad | line_err;
                                hits     <= hits | tile_hit;
                            end
                        end
                        LOCKED: begin
                            if (vs_fall) begin
                                hits     <= 8'd0;
                                line_bad <= 1'b0;
                                if (frame_bad_now) begin
                                    state      <= ALIGN;
                                    locked_r   <= 1'b0;
                                    sync_err_r <= 1'b1;
                                end else begin
                                    slot_code_r  <= hits;
                                    code_err_r   <= is_multi_hot(hits);
                                    slot_valid_r <= 1'b1;
                                end
                            end else begin
                                line_bad <= line_bad | line_err;
                                hits     <= hits | tile_hit;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end

    assign bus.locked     = locked_r;
    assign bus.slot_code  = slot_code_r;
    assign bus.slot_valid = slot_valid_r;
    assign bus.code_err   = code_err_r;
    assign bus.sync_err   = sync_err_r;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb_vga_frame_decoder
//   Directed bench for vga_frame_decoder using a reduced geometry
//   (40-pixel lines, 16-line frames, 6x4 tiles) with the same structure
//   as the full 640x480 layout.
module tb_vga_frame_decoder;
    import vga_timing_pkg::*;

    localparam int T_HS     = 4;
    localparam int T_HBP    = 2;
    localparam int T_LINE   = 40;
    localparam int T_VS     = 2;
    localparam int T_VBP    = 2;
    localparam int T_FRAME  = 16;
    localparam int T_TOL    = 1;
    localparam int T_TW     = 6;
    localparam int T_TH     = 4;
    localparam int T_PITCH  = 7;
    localparam int T_ROW0   = 0;
    localparam int T_ROW1   = 5;
    localparam int T_MARGIN = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   valid_cnt;
    int   sync_cnt;

    vga_frame_decoder_if bus ();

    vga_frame_decoder #(
        .H_SYNC    (T_HS),
        .H_BP      (T_HBP),
        .H_LINE    (T_LINE),
        .V_SYNC    (T_VS),
        .V_BP      (T_VBP),
        .V_FRAME   (T_FRAME),
        .V_TOL     (T_TOL),
        .TILE_W    (T_TW),
        .TILE_H    (T_TH),
        .COL_PITCH (T_PITCH),
        .ROW0_Y    (T_ROW0),
        .ROW1_Y    (T_ROW1),
        .MARGIN    (T_MARGIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz-style clk with a pixel strobe on every second cycle.
    initial begin
        clk        = 1'b0;
        bus.pix_en = 1'b0;
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
            bus.pix_en = ~bus.pix_en;
        end
    end

    // Count one-clk pulses; a pulse stretched over two clks counts twice.
    initial begin
        valid_cnt = 0;
        sync_cnt  = 0;
    end
    always @(negedge clk) begin
        if (bus.slot_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.sync_err === 1'b1)   sync_cnt  <= sync_cnt + 1;
    end

    function automatic logic [15:0] pixel_rgb(input logic [7:0] led, input int x, input int y);
        for (int row = 0; row < 2; row++) begin
            for (int col = 0; col < 4; col++) begin
                int x0;
                int y0;
                x0 = T_HS + T_HBP + col * T_PITCH;
                y0 = T_VS + T_VBP + ((row == 0) ? T_ROW0 : T_ROW1);
                if (led[row * 4 + col] && x >= x0 && x < x0 + T_TW &&
                    y >= y0 && y < y0 + T_TH)
                    return 16'h07E0;
            end
        end
        return 16'h0000;
    endfunction

    // Present one pixel so that the next rising clk edge is a pix_en sample.
    task automatic applyStimulus(input logic hs, input logic vs, input logic [15:0] rgb);
        @(negedge clk);
        #1;
        if (!bus.pix_en) begin
            @(negedge clk);
            #1;
        end
        bus.vga_in_hs = hs;
        bus.vga_in_vs = vs;
        bus.vga_in_r  = rgb[15:11];
        bus.vga_in_g  = rgb[10:5];
        bus.vga_in_b  = rgb[4:0];
    endtask

    task automatic run_frame(input logic [7:0] led, input int lines, input int short_line);
        for (int y = 0; y < lines; y++) begin
            int len;
            len = (y == short_line) ? T_LINE - 1 : T_LINE;
            for (int x = 0; x < len; x++)
                applyStimulus(x >= T_HS, y >= T_VS, pixel_rgb(led, x, y));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b1, 16'h0000);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.vga_in_hs = 1'b1;
        bus.vga_in_vs = 1'b1;
        bus.vga_in_r  = 5'd0;
        bus.vga_in_g  = 6'd0;
        bus.vga_in_b  = 5'd0;

        repeat (4) @(negedge clk);
        #1;
        checkOutput("rst_locked", 32'(bus.locked), 32'd0);
        checkOutput("rst_slot_code", 32'(bus.slot_code), 32'h00);
        checkOutput("rst_slot_valid", 32'(bus.slot_valid), 32'd0);
        checkOutput("rst_code_err", 32'(bus.code_err), 32'd0);
        checkOutput("rst_sync_err", 32'(bus.sync_err), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // f1: first vs fall -> ALIGN
        run_frame(8'h04, T_FRAME, -1);
        checkOutput("f1_locked", 32'(bus.locked), 32'd0);
        // f2: good frame in ALIGN -> LOCKED at its start
        run_frame(8'h04, T_FRAME, -1);
        checkOutput("f2_locked", 32'(bus.locked), 32'd1);
        checkOutput("f2_valid_cnt", 32'(valid_cnt), 32'd0);
        run_frame(8'h04, T_FRAME, -1);
        checkOutput("f3_code", 32'(bus.slot_code), 32'h04);
        checkOutput("f3_code_err", 32'(bus.code_err), 32'd0);
        checkOutput("f3_valid_cnt", 32'(valid_cnt), 32'd1);
        run_frame(8'h01, T_FRAME, -1);
        checkOutput("f4_code", 32'(bus.slot_code), 32'h04);
        run_frame(8'h80, T_FRAME, -1);
        checkOutput("f5_code", 32'(bus.slot_code), 32'h01);
        run_frame(8'h00, T_FRAME, -1);
        checkOutput("f6_code", 32'(bus.slot_code), 32'h80);
        run_frame(8'h21, T_FRAME, -1);
        checkOutput("f7_code", 32'(bus.slot_code), 32'h00);
        checkOutput("f7_code_err", 32'(bus.code_err), 32'd0);
        run_frame(8'h02, T_FRAME, -1);
        checkOutput("f8_code", 32'(bus.slot_code), 32'h21);
        checkOutput("f8_code_err", 32'(bus.code_err), 32'd1);

        // f9 carries one 39-pixel line
        run_frame(8'h08, T_FRAME, 7);
        checkOutput("f9_code", 32'(bus.slot_code), 32'h02);
        checkOutput("f9_code_err", 32'(bus.code_err), 32'd0);
        checkOutput("f9_sync_cnt", 32'(sync_cnt), 32'd0);
        checkOutput("f9_valid_cnt", 32'(valid_cnt), 32'd7);
        checkOutput("f9_locked", 32'(bus.locked), 32'd1);
        run_frame(8'h10, T_FRAME, -1);
        checkOutput("f10_locked", 32'(bus.locked), 32'd0);
        checkOutput("f10_code_held", 32'(bus.slot_code), 32'h02);
        checkOutput("f10_sync_cnt", 32'(sync_cnt), 32'd1);
        run_frame(8'h40, T_FRAME, -1);
        checkOutput("f11_relocked", 32'(bus.locked), 32'd1);
        run_frame(8'h20, T_FRAME, -1);
        checkOutput("f12_code", 32'(bus.slot_code), 32'h40);
        checkOutput("f12_valid_cnt", 32'(valid_cnt), 32'd8);

        // Frame length one short of nominal keeps lock, two short drops it
        run_frame(8'h01, T_FRAME - 1, -1);
        checkOutput("f13_code", 32'(bus.slot_code), 32'h20);
        run_frame(8'h04, T_FRAME - 2, -1);
        checkOutput("f14_code", 32'(bus.slot_code), 32'h01);
        checkOutput("f14_locked", 32'(bus.locked), 32'd1);
        checkOutput("f14_sync_cnt", 32'(sync_cnt), 32'd1);
        run_frame(8'h04, T_FRAME, -1);
        checkOutput("f15_locked", 32'(bus.locked), 32'd0);
        checkOutput("f15_sync_cnt", 32'(sync_cnt), 32'd2);
        checkOutput("f15_code_held", 32'(bus.slot_code), 32'h01);
        run_frame(8'h04, T_FRAME, -1);
        checkOutput("f16_locked", 32'(bus.locked), 32'd1);

        // Partial frame, then asynchronous reset between clock edges
        run_frame(8'h04, 8, -1);
        checkOutput("pre_rst_code", 32'(bus.slot_code), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_locked", 32'(bus.locked), 32'd0);
        checkOutput("async_rst_code", 32'(bus.slot_code), 32'h00);
        checkOutput("async_rst_code_err", 32'(bus.code_err), 32'd0);
        bus.vga_in_hs = 1'b1;
        bus.vga_in_vs = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        run_frame(8'h80, T_FRAME, -1);
        checkOutput("f18_locked", 32'(bus.locked), 32'd0);
        run_frame(8'h80, T_FRAME, -1);
        checkOutput("f19_locked", 32'(bus.locked), 32'd1);
        run_frame(8'h80, T_FRAME, -1);
        checkOutput("f20_code", 32'(bus.slot_code), 32'h80);
        checkOutput("f20_code_err", 32'(bus.code_err), 32'd0);

        // hs held high long enough for exactly one watchdog expiry
        idle(2 * T_LINE + 10);
        checkOutput("wd_sync_cnt", 32'(sync_cnt), 32'd3);
        checkOutput("wd_locked", 32'(bus.locked), 32'd0);
        checkOutput("wd_state", 32'(dut.state), 32'(SEARCH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
